// File: rtl/vga_double_sched_pkg.sv
// Shared timing constants and sequencer state encoding for the
// TV sync generator, scan doubler and its line sequencer.
package vga_double_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACQ,
      ST_LOCK
   } sched_state_t;

   localparam int VGA_LINE_LEN    = 896;
   localparam int VGA_HS_LEN      = 106;
   localparam int VGA_SCANIN_OFS  = 144;
   localparam int VGA_SCANOUT_OFS = 128;
   localparam int VGA_MISS_MAX    = 2;

   localparam int HCNT_W = 10;
   localparam int MISS_W = 4;

endpackage

// File: rtl/vga_double_sched.sv
// Scan doubler sequencer: locks to TV line start, runs two VGA
// lines per TV line and issues page-swap / scan strobes and hsync.
module vga_double_sched
   import vga_double_sched_pkg::*;
#(
   parameter int LINE_LEN    = VGA_LINE_LEN,
   parameter int HS_LEN      = VGA_HS_LEN,
   parameter int SCANIN_OFS  = VGA_SCANIN_OFS,
   parameter int SCANOUT_OFS = VGA_SCANOUT_OFS,
   parameter int MISS_MAX    = VGA_MISS_MAX
) (
   input  logic clk,
   input  logic rst,
   input  logic line_start,
   output logic page_swap,
   output logic scanin_start,
   output logic scanout_start,
   output logic vga_hsync,
   output logic half,
   output logic locked
);

   if (SCANOUT_OFS <= 0) begin : g_err_so_zero
      $error("SCANOUT_OFS must be greater than 0");
   end
   if (SCANIN_OFS >= LINE_LEN) begin : g_err_si
      $error("SCANIN_OFS must be below LINE_LEN");
   end
   if (SCANOUT_OFS >= LINE_LEN) begin : g_err_so
      $error("SCANOUT_OFS must be below LINE_LEN");
   end
   if (HS_LEN >= LINE_LEN) begin : g_err_hs
      $error("HS_LEN must be below LINE_LEN");
   end
   if (LINE_LEN > 1024 || LINE_LEN < 2) begin : g_err_len
      $error("LINE_LEN must be in 2..1024");
   end
   if (MISS_MAX >= (1 << MISS_W)) begin : g_err_miss
      $error("MISS_MAX too large for miss counter");
   end

   localparam logic [HCNT_W-1:0] LAST = HCNT_W'(LINE_LEN - 1);
   localparam logic [HCNT_W-1:0] SI   = HCNT_W'(SCANIN_OFS);
   localparam logic [HCNT_W-1:0] SO   = HCNT_W'(SCANOUT_OFS);
   localparam logic [HCNT_W-1:0] HS   = HCNT_W'(HS_LEN);
   localparam logic [MISS_W-1:0] MMAX = MISS_W'(MISS_MAX);

   sched_state_t      state, state_n;
   logic [HCNT_W-1:0] hcnt, hcnt_n;
   logic              half_q, half_n;
   logic [MISS_W-1:0] miss, miss_n;
   logic              armed;
   logic              ls, wrap, in_phase, run_n;

   // armed masks a pulse coinciding with the reset release edge
   assign ls       = line_start & armed;
   assign wrap     = (hcnt == LAST);
   assign in_phase = wrap & half_q;
   assign run_n    = (state_n != ST_IDLE);

   always_comb begin
      state_n = state;
      hcnt_n  = hcnt;
      half_n  = half_q;
      miss_n  = miss;
      if (state != ST_IDLE) begin
         hcnt_n = wrap ? '0 : hcnt + 1'b1;
         half_n = wrap ? ~half_q : half_q;
      end
      if (ls) begin
         hcnt_n  = '0;
         half_n  = 1'b0;
         miss_n  = '0;
         state_n = (state != ST_IDLE && in_phase) ? ST_LOCK : ST_ACQ;
      end else if (state == ST_LOCK && in_phase) begin
         // MISS_MAX missing pulses are tolerated; the next one drops lock
         if (miss == MMAX) begin
            state_n = ST_ACQ;
            miss_n  = '0;
         end else begin
            miss_n = miss + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         hcnt          <= '0;
         half_q        <= 1'b0;
         miss          <= '0;
         armed         <= 1'b0;
         page_swap     <= 1'b0;
         scanin_start  <= 1'b0;
         scanout_start <= 1'b0;
         vga_hsync     <= 1'b0;
         half          <= 1'b0;
         locked        <= 1'b0;
      end else begin
         state         <= state_n;
         hcnt          <= hcnt_n;
         half_q        <= half_n;
         miss          <= miss_n;
         armed         <= 1'b1;
         page_swap     <= run_n && hcnt_n == '0 && !half_n;
         scanin_start  <= run_n && hcnt_n == SI && !half_n;
         scanout_start <= run_n && hcnt_n == SO;
         vga_hsync     <= run_n && hcnt_n < HS;
         half          <= run_n && half_n;
         locked        <= (state_n == ST_LOCK);
      end
   end

endmodule

// File: tb/tb_vga_double_sched.sv
// Self-checking bench for vga_double_sched: position-based model
// compared every cycle plus hand-computed directed expectations.
module tb_vga_double_sched;

   localparam int LINE = 896;
   localparam int TV   = 2 * LINE;
   localparam int HS   = 106;
   localparam int SI   = 144;
   localparam int SO   = 128;
   localparam int MM   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic line_start = 1'b0;
   logic page_swap, scanin_start, scanout_start;
   logic vga_hsync, half, locked;

   vga_double_sched dut (
      .clk          (clk),
      .rst          (rst),
      .line_start   (line_start),
      .page_swap    (page_swap),
      .scanin_start (scanin_start),
      .scanout_start(scanout_start),
      .vga_hsync    (vga_hsync),
      .half         (half),
      .locked       (locked)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int t      = 0;
   bit rnd_on = 1'b0;

   // model: position within the TV line, lock flag, missed-line count
   bit m_act, m_lk, m_armed;
   int m_p, m_miss;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_act   = 1'b0;
         m_lk    = 1'b0;
         m_armed = 1'b0;
         m_p     = 0;
         m_miss  = 0;
      end else begin
         if (line_start && m_armed) begin
            m_lk   = m_act && (m_p == TV - 1);
            m_act  = 1'b1;
            m_p    = 0;
            m_miss = 0;
         end else if (m_act) begin
            if (m_p == TV - 1 && m_lk) begin
               m_miss++;
               if (m_miss > MM) begin
                  m_lk   = 1'b0;
                  m_miss = 0;
               end
            end
            m_p = (m_p + 1) % TV;
         end
         m_armed = 1'b1;
      end
   end

   bit p_ps, p_si, p_so;
   int c_ps, c_si, c_so;

   always @(negedge clk) begin
      logic [5:0] got, exp;
      exp = {m_act && m_p == 0, m_act && m_p == SI,
             m_act && (m_p % LINE) == SO,
             m_act && (m_p % LINE) < HS,
             m_act && m_p >= LINE, m_lk};
      got = {page_swap, scanin_start, scanout_start,
             vga_hsync, half, locked};
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL outputs time=%0t got=%b exp=%b", $time, got, exp);
      end
      if (p_ps || p_si || p_so) begin
         n_chk++;
         if ((p_ps && page_swap) || (p_si && scanin_start) ||
             (p_so && scanout_start)) begin
            n_fail++;
            $display("FAIL pulse_width time=%0t got=%b%b%b exp=000", $time,
                     page_swap, scanin_start, scanout_start);
         end
      end
      p_ps = page_swap;
      p_si = scanin_start;
      p_so = scanout_start;
      c_ps += int'(page_swap);
      c_si += int'(scanin_start);
      c_so += int'(scanout_start);
   end

   task automatic chk(input string name, input logic got, input logic exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got=%b exp=%b", name, t, got, exp);
      end
   endtask

   task automatic chk_cnt(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s gap=%0d got=%0d exp=%0d", name, t, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      t++;
   endtask

   task automatic upto(input int k);
      while (t < k) step();
   endtask

   // pulse line_start for one cycle; t becomes the offset from that pulse
   task automatic fire();
      #1;
      if (rnd_on) begin
         chk_cnt("page_swap_count", c_ps, 1);
         chk_cnt("scanin_count", c_si, (t >= SI + 1) ? 1 : 0);
         chk_cnt("scanout_count", c_so,
                 ((t >= SO + 1) ? 1 : 0) + ((t >= LINE + SO + 1) ? 1 : 0));
      end
      c_ps = 0;
      c_si = 0;
      c_so = 0;
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      t = 1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_page_swap", page_swap, 1'b0);
      chk("rst_scanin", scanin_start, 1'b0);
      chk("rst_scanout", scanout_start, 1'b0);
      chk("rst_hsync", vga_hsync, 1'b0);
      chk("rst_half", half, 1'b0);
      chk("rst_locked", locked, 1'b0);
      rst = 1'b0;
      step();

      // regular period: acquire, then lock on the second pulse
      fire();
      chk("first_page_swap", page_swap, 1'b1);
      chk("first_locked", locked, 1'b0);
      upto(TV);
      fire();
      chk("lock_page_swap", page_swap, 1'b1);
      chk("lock_locked", locked, 1'b1);
      chk("lock_hsync_start", vga_hsync, 1'b1);
      upto(106);  chk("hsync_last", vga_hsync, 1'b1);
      upto(107);  chk("hsync_end", vga_hsync, 1'b0);
      upto(128);  chk("scanout_pre", scanout_start, 1'b0);
      upto(129);  chk("scanout_h0", scanout_start, 1'b1);
      upto(145);  chk("scanin", scanin_start, 1'b1);
      upto(897);  chk("hsync_h1", vga_hsync, 1'b1);
      chk("half_h1", half, 1'b1);
      upto(1002); chk("hsync_h1_last", vga_hsync, 1'b1);
      upto(1003); chk("hsync_h1_end", vga_hsync, 1'b0);
      upto(1025); chk("scanout_h1", scanout_start, 1'b1);
      upto(TV);
      fire();
      chk("still_locked", locked, 1'b1);

      // early pulse truncates the line and drops lock
      upto(999);
      chk("pre_early_locked", locked, 1'b1);
      upto(1000);
      fire();
      chk("early_unlock", locked, 1'b0);
      chk("early_page_swap", page_swap, 1'b1);
      upto(25);
      chk("early_no_scanout", scanout_start, 1'b0);
      upto(TV);
      fire();
      chk("relock", locked, 1'b1);

      // pulses stop: free-run, lock held for two missing lines
      upto(TV + 1);
      chk("freerun_page_swap", page_swap, 1'b1);
      chk("miss1_locked", locked, 1'b1);
      upto(2 * TV + 1);
      chk("miss2_locked", locked, 1'b1);
      upto(3 * TV);
      chk("miss3_pre_locked", locked, 1'b1);
      upto(3 * TV + 1);
      chk("miss3_unlocked", locked, 1'b0);
      chk("miss3_page_swap", page_swap, 1'b1);

      // reset mid-line while hsync is high
      upto(3 * TV + 50);
      chk("pre_rst_hsync", vga_hsync, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_hsync", vga_hsync, 1'b0);
      chk("async_rst_half", half, 1'b0);
      @(negedge clk);
      line_start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      line_start = 1'b0;
      t = 0;
      upto(2);
      chk("ignored_ls_page_swap", page_swap, 1'b0);
      upto(40);
      chk("ignored_ls_hsync", vga_hsync, 1'b0);
      fire();
      chk("post_rst_page_swap", page_swap, 1'b1);
      chk("post_rst_locked", locked, 1'b0);

      // mixed in-phase / early pulses
      upto(TV);
      fire();
      rnd_on = 1'b1;
      for (int i = 0; i < 12; i++) begin
         int gap;
         gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(200, TV - 1)) : TV;
         upto(gap);
         fire();
      end
      rnd_on = 1'b0;
      upto(20);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
